// File: rtl/sync_fifo_packer.sv
// Read-side packer for the synchronous FIFO: drains narrow FWFT words and
// packs PACK_RATIO of them little-endian into one registered wide word.
// A flush pushes out a partially filled word with lane keep bits and o_last.
module sync_fifo_packer #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PACK_RATIO = 4,
   parameter int unsigned OUT_WIDTH  = DATA_WIDTH * PACK_RATIO,
   parameter int unsigned CNT_WIDTH  = $clog2(PACK_RATIO)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_fifo_valid,
   input  logic [DATA_WIDTH-1:0] i_fifo_data,
   output logic                  o_fifo_ready,
   input  logic                  i_flush,
   output logic                  o_valid,
   output logic [OUT_WIDTH-1:0]  o_data,
   output logic [PACK_RATIO-1:0] o_keep,
   output logic                  o_last,
   input  logic                  i_ready
);

   typedef enum logic [0:0] {StFill, StFlushWait} state_e;

   localparam logic [CNT_WIDTH-1:0] LastLane = CNT_WIDTH'(PACK_RATIO - 1);

   state_e                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [OUT_WIDTH-1:0]   acc_q, acc_d;
   logic                   valid_q, valid_d;
   logic [OUT_WIDTH-1:0]   data_q, data_d;
   logic [PACK_RATIO-1:0]  keep_q, keep_d;
   logic                   last_q, last_d;

   logic                   slot_free;
   logic                   accept;
   logic [CNT_WIDTH:0]     fill_cnt;
   logic [OUT_WIDTH-1:0]   acc_with;

   // Lanes below n are valid.
   function automatic logic [PACK_RATIO-1:0] keep_mask(input logic [CNT_WIDTH:0] n);
      logic [PACK_RATIO-1:0] m;
      for (int k = 0; k < PACK_RATIO; k++) begin
         m[k] = ((CNT_WIDTH+1)'(k) < n);
      end
      return m;
   endfunction

   assign slot_free = ~valid_q | i_ready;

   // Last lane may only be taken when the completed word has somewhere to go.
   assign o_fifo_ready = ~i_rst && (state_q == StFill) && ((cnt_q != LastLane) || slot_free);
   assign accept       = i_fifo_valid & o_fifo_ready;

   // Accumulator view including a word accepted this cycle, and the resulting fill.
   always_comb begin
      acc_with = acc_q;
      if (accept) begin
         acc_with[cnt_q*DATA_WIDTH +: DATA_WIDTH] = i_fifo_data;
      end
      fill_cnt = {1'b0, cnt_q} + (CNT_WIDTH+1)'(accept);
   end

   // Next-state: lane counter, accumulator, output register and flush FSM.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      valid_d = valid_q & ~i_ready;
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      unique case (state_q)
         StFill: begin
            if (accept) begin
               acc_d = acc_with;
               cnt_d = cnt_q + 1'b1;
            end
            if (accept && (cnt_q == LastLane)) begin
               // Full word; a coincident flush just marks it as last.
               valid_d = 1'b1;
               data_d  = acc_with;
               keep_d  = '1;
               last_d  = i_flush;
               cnt_d   = '0;
               acc_d   = '0;
            end else if (i_flush && (fill_cnt != '0)) begin
               if (slot_free) begin
                  valid_d = 1'b1;
                  data_d  = acc_with;
                  keep_d  = keep_mask(fill_cnt);
                  last_d  = 1'b1;
                  cnt_d   = '0;
                  acc_d   = '0;
               end else begin
                  // acc_d/cnt_d already include any same-cycle word.
                  state_d = StFlushWait;
               end
            end
         end
         StFlushWait: begin
            if (slot_free) begin
               valid_d = 1'b1;
               data_d  = acc_q;
               keep_d  = keep_mask({1'b0, cnt_q});
               last_d  = 1'b1;
               cnt_d   = '0;
               acc_d   = '0;
               state_d = StFill;
            end
         end
         default: state_d = StFill;
      endcase
   end

   // State and output registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= StFill;
         cnt_q   <= '0;
         acc_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         keep_q  <= keep_d;
         last_q  <= last_d;
      end
   end

   assign o_valid = valid_q;
   assign o_data  = data_q;
   assign o_keep  = keep_q;
   assign o_last  = last_q;

endmodule
